// File: rtl/trigger_framer.sv
// trigger_framer: frames the free-running ADC stream around trigger rising edges,
// with pre-trigger history, post-frame holdoff and a FWFT output FIFO.
module trigger_framer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_TRIGGER    = 1000,
  parameter int PRE_SAMPLES            = 16,
  parameter int HOLDOFF                = 64,
  parameter int FIFO_DEPTH             = 16
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  output logic                                  s00_axis_tready,
  input  logic                                  trigger_in,
  input  logic                                  arm_in,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic [15:0]                           frame_count_out,
  output logic                                  overrun_out,
  output logic                                  busy_out
);
  localparam int DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, FILL, ARMED, CAPTURE, HOLD} state_t;
  state_t state_q, state_d;
  logic trig_q, ovr_q;
  logic [15:0] hist_q, cnt_q, frame_q;
  logic [31:0] hold_q;
  logic [DW:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic beat, evt, empty, full, pop, wr, ovf, push, last, hold_done;
  logic [DW-1:0] tap;
  assign beat      = s00_axis_tvalid & ~s00_axis_areset;
  assign evt       = trigger_in & ~trig_q;
  assign empty     = wptr_q == rptr_q;
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = ~empty & m00_axis_tready;
  assign wr        = (state_q == CAPTURE) & beat;
  // a same-cycle pop frees the slot, so only a write into a full, non-draining FIFO overruns
  assign ovf       = wr & full & ~pop;
  assign push      = wr & ~ovf;
  assign last      = cnt_q == 16'(SAMPLES_PER_TRIGGER - 1);
  assign hold_done = (hold_q + 32'd1) >= 32'(HOLDOFF);
  generate
    if (PRE_SAMPLES == 0) begin : g_nodl
      assign tap = s00_axis_tdata;
    end else begin : g_dl
      logic [DW-1:0] dl_q [PRE_SAMPLES];
      always_ff @(posedge s00_axis_aclk) begin
        if (beat) begin
          dl_q[0] <= s00_axis_tdata;
          for (int i = 1; i < PRE_SAMPLES; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign tap = dl_q[PRE_SAMPLES-1];
    end
  endgenerate
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_in) state_d = (hist_q < 16'(PRE_SAMPLES)) ? FILL : ARMED;
      FILL:    state_d = !arm_in ? IDLE : (hist_q == 16'(PRE_SAMPLES)) ? ARMED : FILL;
      ARMED:   state_d = !arm_in ? IDLE : evt ? CAPTURE : ARMED;
      CAPTURE: if (ovf || (push && last)) state_d = HOLD;
      HOLD:    if (hold_done) state_d = arm_in ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_out = state_q == CAPTURE;
  end
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      trig_q  <= 1'b0;
      hist_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      trig_q  <= trigger_in;
      hist_q  <= (beat && hist_q < 16'(PRE_SAMPLES)) ? hist_q + 16'd1 : hist_q;
      cnt_q   <= (state_q == CAPTURE) ? cnt_q + {15'd0, push} : '0;
      hold_q  <= (state_q == HOLD) ? hold_q + 32'd1 : '0;
      frame_q <= frame_q + {15'd0, push & last};
      ovr_q   <= ovr_q | ovf;
      wptr_q  <= wptr_q + {{AW{1'b0}}, push};
      rptr_q  <= rptr_q + {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge s00_axis_aclk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {last, tap};
  end
  assign s00_axis_tready = ~s00_axis_areset;
  assign m00_axis_tvalid = ~empty;
  assign {m00_axis_tlast, m00_axis_tdata} = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign m00_axis_tstrb  = '1;
  assign frame_count_out = frame_q;
  assign overrun_out     = ovr_q;
endmodule

// File: tb/tb_trigger_framer.sv
// tb_trigger_framer: directed and randomized checks of trigger_framer against a queue-based frame model.
module tb_trigger_framer;
  localparam int P = 4;
  localparam int SPT = 1000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, s_tvalid, s_tready, trigger, arm, m_tready, m_tvalid, m_tlast, busy, ovr;
  logic [31:0] s_tdata, m_tdata;
  logic [3:0] m_tstrb;
  logic [15:0] fcnt;
  logic [31:0] xs[$];
  logic [32:0] out[$];
  int ks[$];
  int evt_k, k, checks = 0, passes = 0, fails = 0;
  logic trg_prev = 1'b0;

  trigger_framer #(
    .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32), .SAMPLES_PER_TRIGGER(SPT),
    .PRE_SAMPLES(P), .HOLDOFF(64), .FIFO_DEPTH(16)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
    .s00_axis_tready(s_tready), .trigger_in(trigger), .arm_in(arm), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast), .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .frame_count_out(fcnt), .overrun_out(ovr), .busy_out(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: logs the pop and the accepted beat of the coming edge, then advances one cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic trg, input logic r);
    s_tvalid = v;
    s_tdata = d;
    trigger = trg;
    m_tready = r;
    if (!rst && m_tvalid && r) out.push_back({m_tlast, m_tdata});
    if (!rst && v) xs.push_back(d);
    if (trg && !trg_prev) evt_k = xs.size();
    trg_prev = rst ? 1'b0 : trg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(1'b0, 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    xs.delete();
    out.delete();
    ks.delete();
  endtask

  // Expected output: every captured frame is history-shifted by P, SPT beats, tlast on the final one.
  task automatic check_frames(input string tag);
    logic [32:0] exp[$];
    int mism;
    mism = 0;
    foreach (ks[f])
      for (int i = 0; i < SPT; i++) exp.push_back({i == SPT - 1, xs[ks[f] - P + i]});
    chk({tag, "_len"}, out.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out.size(); i++) if (out[i] !== exp[i]) mism++;
    chk({tag, "_mismatches"}, mism, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; s_tvalid = 1'b0; s_tdata = '0; trigger = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    do_reset(3);
    rst = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_fcnt", fcnt, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("tstrb", m_tstrb, 15);
    rst = 1'b0;
    arm = 1'b1;
    // ramp data = beat index; re-pulses in CAPTURE (300, 1500) and HOLDOFF (1050) must be ignored
    for (int i = 0; i <= 2651; i++) begin
      step(1'b1, i, (i == 20 || i == 300 || i == 1050 || i == 1085 || i == 1500 || i == 2150), 1'b1);
      if (i == 0) chk("s_tready_run", s_tready, 1);
      if (i == 19) chk("busy_pre", busy, 0);
      if (i == 20) begin
        ks.push_back(evt_k);
        chk("k_first", evt_k, 21);
        chk("busy_after_evt", busy, 1);
      end
      if (i == 21) chk("first_out_latency", m_tvalid, 1);
      if (i == 1030) begin
        chk("fcnt_one", fcnt, 1);
        chk("busy_holdoff", busy, 0);
      end
      if (i == 1085) ks.push_back(evt_k);
      if (i == 2100) begin
        chk("fcnt_two", fcnt, 2);
        if (out.size() > 0) chk("first_beat", out[0][31:0], 17);
        if (out.size() >= SPT) chk("tlast_beat", out[SPT-1], {1'b1, 32'd1016});
        check_frames("two_frames");
      end
      if (i == 2650) begin
        chk("busy_mid", busy, 1);
        chk("tvalid_mid", m_tvalid, 1);
      end
    end
    rst = 1'b1;
    step(1'b1, 32'd0, 1'b0, 1'b1);
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_fcnt", fcnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tdata", m_tdata, 0);
    do_reset(1);
    // early trigger while history is filling is ignored; later one produces a clean frame
    for (int i = 0; i <= 1100; i++) begin
      step(1'b1, i * 3 + 5000, (i == 1 || i == 10), 1'b1);
      if (i == 10) ks.push_back(evt_k);
    end
    chk("fill_fcnt", fcnt, 1);
    chk("fill_ovr", ovr, 0);
    check_frames("fill_frame");
    // downstream stalled during capture: 16 entries held, then overrun
    do_reset(2);
    for (int i = 0; i <= 100; i++) begin
      step(1'b1, i, (i == 10), 1'b0);
      if (i == 10) k = evt_k;
      if (i == 26) chk("ovr_before_full", ovr, 0);
      if (i == 27) chk("ovr_on_full", ovr, 1);
    end
    chk("ovr_fcnt", fcnt, 0);
    chk("ovr_busy", busy, 0);
    chk("ovr_held_valid", m_tvalid, 1);
    for (int i = 101; i <= 140; i++) step(1'b1, i, 1'b0, 1'b1);
    chk("drain_len", out.size(), 16);
    begin
      int mism;
      mism = 0;
      foreach (out[j]) if (out[j] !== {1'b0, xs[k - P + j]}) mism++;
      chk("drain_mismatches", mism, 0);
    end
    chk("drain_empty", m_tvalid, 0);
    chk("ovr_sticky", ovr, 1);
    // random data, gapped valid and 50% ready; valid throttled so the FIFO can never fill
    do_reset(2);
    for (int c = 0; c < 10; c++) step(1'b1, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, $urandom, 1'b1, 1'($urandom_range(0, 1)));
    k = evt_k;
    ks.push_back(k);
    for (int c = 0; c < 20000 && out.size() < SPT; c++) begin
      int wrn, occ;
      wrn = xs.size() - k;
      if (wrn > SPT) wrn = SPT;
      occ = wrn - out.size();
      step(($urandom_range(0, 3) == 0) && occ < 12, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("rand_ovr", ovr, 0);
    chk("rand_fcnt", fcnt, 1);
    check_frames("rand_frame");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
